// File: rtl/linebuf_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// linebuf_ctrl
// FIFO-style controller for an external line-buffer RAM. It tracks the write
// and read pointers and the number of stored words, derives the full and
// empty flags, and drives the RAM address/enable/data lines. Read data comes
// back from the RAM combinationally and is registered onto rd_data with a
// one-cycle rd_valid pulse.
//
// Optional feature: define LINEBUF_CTRL_DROPCNT_EN to add the 8-bit
// saturating drop_cnt output (writes rejected because the buffer was full).
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear request
//   wr_en      producer write request
//   wr_data    producer write word
//   rd_en      consumer read request
//   rd_data    registered read word
//   rd_valid   one-cycle pulse, rd_data carries a fresh word
//   full       buffer holds DEPTH words (also high while flushing)
//   empty      buffer holds no words (also high while flushing)
//   count      number of stored words
//   ram_we     RAM write enable
//   ram_waddr  RAM write address (the RAM stores at ram_waddr-1)
//   ram_raddr  RAM read address
//   ram_dq_i   RAM write data
//   ram_dq_o   RAM combinational read data
//   drop_cnt   rejected-write counter (LINEBUF_CTRL_DROPCNT_EN only)
// ---------------------------------------------------------------------------
module linebuf_ctrl #(
    parameter int WIDTH  = 1,
    parameter int DEPTH  = 1500,
    parameter int DEPBIT = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [DEPBIT-1:0] count,
    output logic              ram_we,
    output logic [DEPBIT-1:0] ram_waddr,
    output logic [DEPBIT-1:0] ram_raddr,
    output logic [WIDTH-1:0]  ram_dq_i,
    input  logic [WIDTH-1:0]  ram_dq_o
`ifdef LINEBUF_CTRL_DROPCNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY,
        RUN,
        FULL,
        FLUSH
    } state_t;

    localparam logic [DEPBIT-1:0] LAST_ADDR = DEPBIT'(DEPTH - 1);
    localparam logic [DEPBIT-1:0] MAX_COUNT = DEPBIT'(DEPTH);

    state_t            state;
    logic [DEPBIT-1:0] wptr;
    logic [DEPBIT-1:0] rptr;
    logic [DEPBIT-1:0] count_next;
    logic              wr_ok;
    logic              rd_ok;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [DEPBIT-1:0] advance(input logic [DEPBIT-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + DEPBIT'(1);
    endfunction

    // FLUSH reports both flags high, which blocks every request for that cycle.
    assign full  = (state == FULL)  || (state == FLUSH);
    assign empty = (state == EMPTY) || (state == FLUSH);

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Gated by rst_n so no RAM write can slip out while reset is held.
    assign ram_we    = wr_ok && rst_n;
    assign ram_waddr = wptr + DEPBIT'(1);
    assign ram_raddr = rptr;
    assign ram_dq_i  = wr_data;

    always_comb begin
        count_next = count;
        if (wr_ok && !rd_ok) begin
            count_next = count + DEPBIT'(1);
        end else if (rd_ok && !wr_ok) begin
            count_next = count - DEPBIT'(1);
        end
    end

    // State follows the updated count; flush overrides everything and parks
    // the controller in FLUSH with cleared pointers for as long as it is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (flush) begin
            state    <= FLUSH;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                rd_data <= ram_dq_o;
                rptr    <= advance(rptr);
            end
            if (wr_ok) begin
                wptr <= advance(wptr);
            end
            count <= count_next;
            if (count_next == '0) begin
                state <= EMPTY;
            end else if (count_next == MAX_COUNT) begin
                state <= FULL;
            end else begin
                state <= RUN;
            end
        end
    end

`ifdef LINEBUF_CTRL_DROPCNT_EN
    // Counts write attempts refused because the buffer was full; saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'd0;
        end else if (flush || state == FLUSH) begin
            drop_cnt <= 8'd0;
        end else if (wr_en && full && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_linebuf_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_linebuf_ctrl
// Drives linebuf_ctrl against a small behavioural RAM and a queue-based
// reference model. The driver checks flags and RAM-side signals every cycle
// and pushes expected read words into a scoreboard; an independent monitor
// pops the scoreboard whenever rd_valid appears.
// ---------------------------------------------------------------------------
module tb_linebuf_ctrl;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 1500;
    localparam int DEPBIT = 11;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              wr_en;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_en;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [DEPBIT-1:0] count;
    logic              ram_we;
    logic [DEPBIT-1:0] ram_waddr;
    logic [DEPBIT-1:0] ram_raddr;
    logic [WIDTH-1:0]  ram_dq_i;
    logic [WIDTH-1:0]  ram_dq_o;
`ifdef LINEBUF_CTRL_DROPCNT_EN
    logic [7:0]        drop_cnt;
`endif

    linebuf_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPBIT(DEPBIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_dq_i  (ram_dq_i),
        .ram_dq_o  (ram_dq_o)
`ifdef LINEBUF_CTRL_DROPCNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM: stores at waddr-1, reads combinationally.
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_we) mem[int'(ram_waddr) - 1] <= ram_dq_i;
    end
    assign ram_dq_o = mem[int'(ram_raddr) % DEPTH];

    // Reference model state
    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] sb [$];
    int  model_wptr;
    int  model_rptr;
    bit  model_flush;
    int  acc_wr;
    int  acc_rd;
    int  total;
    int  bad;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive inputs, check this cycle's outputs against
    // the model, then advance the model and wait for the next negedge.
    task automatic applyStimulus(input bit wr, input bit rd, input bit fl, input logic [WIDTH-1:0] data);
        bit exp_full;
        bit exp_empty;
        bit w_acc;
        bit r_acc;
        wr_en   = wr;
        rd_en   = rd;
        flush   = fl;
        wr_data = data;
        #1;
        exp_full  = model_flush || (model_q.size() == DEPTH);
        exp_empty = model_flush || (model_q.size() == 0);
        w_acc = wr && !exp_full;
        r_acc = rd && !exp_empty;
        checkOutput("count", 32'(count), 32'(model_q.size()));
        checkOutput("full", 32'(full), 32'(exp_full));
        checkOutput("empty", 32'(empty), 32'(exp_empty));
        checkOutput("ram_we", 32'(ram_we), 32'(w_acc));
        checkOutput("ram_raddr", 32'(ram_raddr), 32'(model_rptr));
        if (w_acc) begin
            checkOutput("ram_waddr", 32'(ram_waddr), 32'(model_wptr + 1));
            checkOutput("ram_dq_i", 32'(ram_dq_i), 32'(data));
        end
        if (fl) begin
            model_q.delete();
            model_wptr  = 0;
            model_rptr  = 0;
            model_flush = 1'b1;
        end else begin
            model_flush = 1'b0;
            if (r_acc) begin
                sb.push_back(model_q.pop_front());
                model_rptr = (model_rptr + 1) % DEPTH;
                acc_rd++;
            end
            if (w_acc) begin
                model_q.push_back(data);
                model_wptr = (model_wptr + 1) % DEPTH;
                acc_wr++;
            end
        end
        @(negedge clk);
    endtask

    // Monitor: every rd_valid must match the oldest outstanding expected word,
    // and every expected word must appear exactly one cycle after acceptance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("rd_valid_spurious", 32'd1, 32'd0);
                end else begin
                    checkOutput("rd_data", 32'(rd_data), 32'(sb.pop_front()));
                end
            end else if (sb.size() > 0) begin
                checkOutput("rd_valid_missing", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    // Watchdog
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] abc [3];
        int iter;
        total = 0;
        bad = 0;
        acc_wr = 0;
        acc_rd = 0;
        model_wptr = 0;
        model_rptr = 0;
        model_flush = 1'b0;
        rst_n = 1'b0;
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_data = '0;

        // Reset values before any clock edge
        #2;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
        checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Three words A,B,C in, then out in order
        for (int i = 0; i < 3; i++) abc[i] = WIDTH'($urandom);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, abc[i]);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        // Fill to DEPTH, then one rejected write
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b0, WIDTH'($urandom));
        applyStimulus(1'b1, 1'b0, 1'b0, WIDTH'($urandom));

        // Simultaneous write and read at full
        applyStimulus(1'b1, 1'b1, 1'b0, WIDTH'($urandom));
        checkOutput("count_after_full_wr_rd", 32'(count), 32'(DEPTH - 1));

        // Drain, including a read+write at empty boundary
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, WIDTH'($urandom));
        applyStimulus(1'b0, 1'b1, 1'b0, '0);

        // Random interleaved traffic long enough to wrap both pointers twice
        acc_wr = 0;
        acc_rd = 0;
        iter = 0;
        while ((acc_wr < 3100 || acc_rd < 3100) && iter < 20000) begin
            applyStimulus($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 1'b0,
                          WIDTH'($urandom));
            iter++;
        end
        checkOutput("wrap_traffic_done", 32'(acc_wr >= 3100 && acc_rd >= 3100), 32'd1);

        // Drain, then flush at count=37
        while (model_q.size() > 0) applyStimulus(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 37; i++) applyStimulus(1'b1, 1'b0, 1'b0, WIDTH'($urandom));
        checkOutput("pre_flush_count", 32'(count), 32'd37);
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, WIDTH'($urandom));
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, WIDTH'($urandom));
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        // Mid-stream asynchronous reset
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, i[0], 1'b0, WIDTH'($urandom));
        wr_en = 1'b1;
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_count", 32'(count), 32'd0);
        checkOutput("async_rst_full", 32'(full), 32'd0);
        checkOutput("async_rst_empty", 32'(empty), 32'd1);
        checkOutput("async_rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("async_rst_rd_data", 32'(rd_data), 32'd0);
        checkOutput("async_rst_ram_we", 32'(ram_we), 32'd0);
        checkOutput("async_rst_raddr", 32'(ram_raddr), 32'd0);
        model_q.delete();
        sb.delete();
        model_wptr = 0;
        model_rptr = 0;
        model_flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, WIDTH'($urandom));
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
